uart_tx_controller: RTL and testbench



---
 rtl/uart_tx_controller_if.sv | 27 ++
 rtl/uart_tx_controller.sv | 127 ++++++++++++
 tb/tb_uart_tx_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_controller_if.sv
// rtl/uart_tx_controller_if.sv - send/ack handshake and serial line bundle for the UART transmitter
`timescale 1ns/1ps
interface uart_tx_controller_if;
    logic       send;
    logic [7:0] din;
    logic       tx_out;
    logic       busy;
    logic       done;

    // User side: requests frames and watches the acknowledge
    modport master (
        output send,
        output din,
        input  tx_out,
        input  busy,
        input  done
    );

    // Controller side: accepts requests and drives the line
    modport slave (
        input  send,
        input  din,
        output tx_out,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - UART transmit frame sequencer with baud timer and optional parity
`timescale 1ns/1ps
module uart_tx_controller #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter bit PARITY_EN     = 1'b1,
    parameter bit PARITY_ODD    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_controller_if.slave   bus
);
    localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
    localparam int TW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] TICK_AT = TW'(BAUD_DIV - 1);

    // A bit period shorter than two clocks cannot be timed by this counter
    generate
        if (BAUD_DIV < 2) begin : g_bad_baud_div
            $error("uart_tx_controller: BAUD_DIV must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        ACK   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick;

    assign tick = (timer_q == TICK_AT);

    // Next-state, timer, bit counter and the output values for the next cycle
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        par_d   = par_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.send) begin
                    state_d = START;
                    data_d  = bus.din;
                    par_d   = PARITY_ODD ? ~^bus.din : ^bus.din;
                    cnt_d   = 3'd0;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    // Wraps 7 -> 0 on the last data bit, which also ends DATA
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = PARITY_EN ? PAR : STOP;
                end
            end
            PAR: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) state_d = ACK;
            end
            ACK: begin
                if (!bus.send) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Timer restarts at each bit boundary so every bit is exactly BAUD_DIV cycles
        if ((state_d != state_q) || tick || (state_q == IDLE) || (state_q == ACK)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        // Outputs are computed from the next state so they can be registered
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[cnt_d];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d == START) || (state_d == DATA) || (state_d == PAR) || (state_d == STOP);
        done_d = (state_d == ACK);
    end

    // State and registered outputs; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            cnt_q   <= 3'd0;
            data_q  <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb/tb_uart_tx_controller.sv - self-checking bench for uart_tx_controller
`timescale 1ns/1ps
module tb_uart_tx_controller;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    uart_tx_controller_if p_if ();
    uart_tx_controller_if n_if ();

    uart_tx_controller #(
        .CLK_FREQUENCY (4),
        .BAUD_RATE     (1),
        .PARITY_EN     (1'b1),
        .PARITY_ODD    (1'b1)
    ) dut_p (
        .clk (clk),
        .rst (rst),
        .bus (p_if.slave)
    );

    uart_tx_controller #(
        .CLK_FREQUENCY (4),
        .BAUD_RATE     (1),
        .PARITY_EN     (1'b0),
        .PARITY_ODD    (1'b1)
    ) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (n_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        bit         no_par;
        logic       par;
        bit         chg;
        logic [7:0] alt;
        int         hold;
    } vec_t;

    vec_t tbl[$];
    logic exp_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input bit s);
        return s ? n_if.tx_out : p_if.tx_out;
    endfunction

    function automatic logic get_busy(input bit s);
        return s ? n_if.busy : p_if.busy;
    endfunction

    function automatic logic get_done(input bit s);
        return s ? n_if.done : p_if.done;
    endfunction

    task automatic set_send(input bit s, input logic v);
        if (s) n_if.send = v;
        else   p_if.send = v;
    endtask

    task automatic set_din(input bit s, input logic [7:0] v);
        if (s) n_if.din = v;
        else   p_if.din = v;
    endtask

    // One full frame: expected line bits are queued when send is raised and
    // popped one per cycle as the line is observed.
    task automatic run_frame(input bit s, input logic [7:0] b, input logic par,
                             input bit chg, input logic [7:0] alt, input int hold);
        logic e;
        int   c;
        for (int k = 0; k < 4; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 4; k++) exp_q.push_back(b[i]);
        if (!s)
            for (int k = 0; k < 4; k++) exp_q.push_back(par);
        for (int k = 0; k < 4; k++) exp_q.push_back(1'b1);

        set_din(s, b);
        set_send(s, 1'b1);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (chg && c == 20) set_din(s, alt);
            e = exp_q.pop_front();
            check($sformatf("tx din=%0h seg%0d cyc%0d", b, c / 4, c), {7'd0, get_tx(s)}, {7'd0, e});
            check($sformatf("busy din=%0h cyc%0d", b, c), {7'd0, get_busy(s)}, 8'd1);
            check($sformatf("done_low din=%0h cyc%0d", b, c), {7'd0, get_done(s)}, 8'd0);
            c++;
        end

        @(negedge clk);
        check("done_rise", {7'd0, get_done(s)}, 8'd1);
        check("busy_after_frame", {7'd0, get_busy(s)}, 8'd0);
        check("tx_idle_in_ack", {7'd0, get_tx(s)}, 8'd1);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check($sformatf("hold_done h%0d", h), {7'd0, get_done(s)}, 8'd1);
            check($sformatf("hold_tx h%0d", h), {7'd0, get_tx(s)}, 8'd1);
            check($sformatf("hold_busy h%0d", h), {7'd0, get_busy(s)}, 8'd0);
        end

        set_send(s, 1'b0);
        @(negedge clk);
        check("done_fall", {7'd0, get_done(s)}, 8'd0);
        check("tx_idle_after_ack", {7'd0, get_tx(s)}, 8'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        p_if.send = 1'b0;
        p_if.din  = 8'h00;
        n_if.send = 1'b0;
        n_if.din  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_p",   {7'd0, p_if.tx_out}, 8'd1);
        check("rst_busy_p", {7'd0, p_if.busy},   8'd0);
        check("rst_done_p", {7'd0, p_if.done},   8'd0);
        check("rst_tx_n",   {7'd0, n_if.tx_out}, 8'd1);
        check("rst_busy_n", {7'd0, n_if.busy},   8'd0);
        check("rst_done_n", {7'd0, n_if.done},   8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tx_p", {7'd0, p_if.tx_out}, 8'd1);

        // din, no_par(select dut_n), parity bit, din change, new din, hold cycles
        tbl.push_back(vec_t'{8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 0});
        tbl.push_back(vec_t'{8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 0});
        tbl.push_back(vec_t'{8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 0});
        tbl.push_back(vec_t'{8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 0});
        tbl.push_back(vec_t'{8'hA5, 1'b0, 1'b1, 1'b1, 8'h3C, 0});
        tbl.push_back(vec_t'{8'h80, 1'b1, 1'b0, 1'b0, 8'h00, 0});
        tbl.push_back(vec_t'{8'h07, 1'b0, 1'b0, 1'b0, 8'h00, 20});
        tbl.push_back(vec_t'{8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 0});

        foreach (tbl[i])
            run_frame(tbl[i].no_par, tbl[i].din, tbl[i].par, tbl[i].chg, tbl[i].alt, tbl[i].hold);

        // Reset during data bit 3 of a 0x00 frame
        p_if.din  = 8'h00;
        p_if.send = 1'b1;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            check($sformatf("pre_rst_tx cyc%0d", c), {7'd0, p_if.tx_out}, 8'd0);
        end
        rst = 1'b1;
        p_if.send = 1'b0;
        @(negedge clk);
        check("abort_tx",   {7'd0, p_if.tx_out}, 8'd1);
        check("abort_busy", {7'd0, p_if.busy},   8'd0);
        check("abort_done", {7'd0, p_if.done},   8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle_tx",   {7'd0, p_if.tx_out}, 8'd1);
        check("post_rst_idle_done", {7'd0, p_if.done},   8'd0);
        run_frame(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
